// File: rtl/memgame_round_ctrl.sv
// Round sequencer for the memorization game: captures a target, runs the
// display phase, collects the user's hex digits, compares them with the
// target, shows the result and keeps score and lives.
module memgame_round_ctrl #(
    parameter  int DIGITS       = 4,
    parameter  int SHOW_TICKS   = 3,
    parameter  int RESULT_TICKS = 2,
    parameter  int MAX_LIVES    = 3,
    parameter  int SCORE_W      = 8,
    localparam int W            = 4 * DIGITS,
    localparam int CW           = $clog2(DIGITS + 1),
    localparam int LW           = $clog2(MAX_LIVES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic [W-1:0]       randInt,
    input  logic [3:0]         digit_in,
    input  logic               digit_valid,
    input  logic               clear,
    input  logic               submit,
    output logic               displayPhase,
    output logic [W-1:0]       target,
    output logic [W-1:0]       userInt,
    output logic [CW-1:0]      digit_cnt,
    output logic               inputReady,
    output logic               result_valid,
    output logic               correct,
    output logic [SCORE_W-1:0] score,
    output logic [LW-1:0]      lives,
    output logic               game_over
);

    localparam int TMAX = (SHOW_TICKS > RESULT_TICKS) ? SHOW_TICKS : RESULT_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHOW   = 3'd1,
        ENTER  = 3'd2,
        CHECK  = 3'd3,
        RESULT = 3'd4,
        OVER   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [W-1:0]       target_q, target_d;
    logic [W-1:0]       user_int_q, user_int_d;
    logic [CW-1:0]      digit_cnt_q, digit_cnt_d;
    logic               correct_q, correct_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LW-1:0]      lives_q, lives_d;
    logic               display_phase_q, display_phase_d;
    logic               input_ready_q, input_ready_d;
    logic               result_valid_q, result_valid_d;
    logic               game_over_q, game_over_d;

    // Next-state, datapath updates and registered phase flags.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        target_d    = target_q;
        user_int_d  = user_int_q;
        digit_cnt_d = digit_cnt_q;
        correct_d   = correct_q;
        score_d     = score_q;
        lives_d     = lives_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SHOW;
                    target_d    = randInt;
                    score_d     = '0;
                    lives_d     = LW'(MAX_LIVES);
                    user_int_d  = '0;
                    digit_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHOW: begin
                if (tick) begin
                    if (tick_cnt_q == TW'(SHOW_TICKS - 1)) begin
                        state_d = ENTER;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ENTER: begin
                // clear beats everything; an accepted submit drops a same-cycle digit
                if (clear) begin
                    user_int_d  = '0;
                    digit_cnt_d = '0;
                end else if (submit && input_ready_q) begin
                    state_d = CHECK;
                end else if (digit_valid && (digit_cnt_q < CW'(DIGITS))) begin
                    user_int_d  = (user_int_q << 4) | W'(digit_in);
                    digit_cnt_d = digit_cnt_q + CW'(1);
                end else begin
                    state_d = ENTER;
                end
            end
            CHECK: begin
                correct_d = (user_int_q == target_q);
                state_d   = RESULT;
            end
            RESULT: begin
                if (tick && (tick_cnt_q == TW'(RESULT_TICKS - 1))) begin
                    correct_d   = 1'b0;
                    user_int_d  = '0;
                    digit_cnt_d = '0;
                    if (correct_q) begin
                        if (score_q != {SCORE_W{1'b1}}) begin
                            score_d = score_q + SCORE_W'(1);
                        end else begin
                            score_d = score_q;
                        end
                        target_d = randInt;
                        state_d  = SHOW;
                    end else begin
                        // losing the last life ends the game; otherwise replay the same target
                        lives_d = lives_q - LW'(1);
                        if (lives_q == LW'(1)) begin
                            state_d = OVER;
                        end else begin
                            state_d = SHOW;
                        end
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            OVER: begin
                if (start) begin
                    state_d = IDLE;
                end else begin
                    state_d = OVER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_d;
        end

        display_phase_d = (state_d == SHOW);
        result_valid_d  = (state_d == RESULT);
        game_over_d     = (state_d == OVER);
        input_ready_d   = (state_d == ENTER) && (digit_cnt_d == CW'(DIGITS));
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            tick_cnt_q      <= '0;
            target_q        <= '0;
            user_int_q      <= '0;
            digit_cnt_q     <= '0;
            correct_q       <= 1'b0;
            score_q         <= '0;
            lives_q         <= LW'(MAX_LIVES);
            display_phase_q <= 1'b0;
            input_ready_q   <= 1'b0;
            result_valid_q  <= 1'b0;
            game_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            target_q        <= target_d;
            user_int_q      <= user_int_d;
            digit_cnt_q     <= digit_cnt_d;
            correct_q       <= correct_d;
            score_q         <= score_d;
            lives_q         <= lives_d;
            display_phase_q <= display_phase_d;
            input_ready_q   <= input_ready_d;
            result_valid_q  <= result_valid_d;
            game_over_q     <= game_over_d;
        end
    end

    assign displayPhase = display_phase_q;
    assign target       = target_q;
    assign userInt      = user_int_q;
    assign digit_cnt    = digit_cnt_q;
    assign inputReady   = input_ready_q;
    assign result_valid = result_valid_q;
    assign correct      = correct_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_memgame_round_ctrl.sv
// Self-checking bench for memgame_round_ctrl: directed scenarios with literal
// expectations plus randomized play checked against a behavioural game model.
module tb_memgame_round_ctrl;

    localparam int ST = 3;
    localparam int RT = 2;

    logic        clk = 1'b0;
    logic        rst, tick, start, digit_valid, clear, submit;
    logic [15:0] randInt;
    logic [3:0]  digit_in;
    logic        displayPhase, inputReady, result_valid, correct, game_over;
    logic [15:0] target, userInt;
    logic [2:0]  digit_cnt;
    logic [7:0]  score;
    logic [1:0]  lives;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    memgame_round_ctrl #(.DIGITS(4), .SHOW_TICKS(ST), .RESULT_TICKS(RT),
                         .MAX_LIVES(3), .SCORE_W(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .randInt(randInt),
        .digit_in(digit_in), .digit_valid(digit_valid), .clear(clear),
        .submit(submit), .displayPhase(displayPhase), .target(target),
        .userInt(userInt), .digit_cnt(digit_cnt), .inputReady(inputReady),
        .result_valid(result_valid), .correct(correct), .score(score),
        .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural game model ----------------
    typedef enum int {M_IDLE, M_SHOW, M_ENTER, M_CHECK, M_RESULT, M_OVER} mphase_t;
    mphase_t    m_phase = M_IDLE;
    logic [3:0] m_digits[$];
    int         m_target = 0, m_score = 0, m_lives = 3, m_ticks = 0;
    bit         m_correct = 1'b0;

    function automatic int entry_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + int'(m_digits[i]);
        return v;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_phase = M_IDLE; m_digits = {}; m_target = 0; m_score = 0;
            m_lives = 3; m_ticks = 0; m_correct = 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (start) begin
                    m_phase = M_SHOW; m_target = int'(randInt); m_score = 0;
                    m_lives = 3; m_digits = {}; m_ticks = 0;
                end
                M_SHOW: if (tick) begin
                    m_ticks++;
                    if (m_ticks == ST) begin m_phase = M_ENTER; m_ticks = 0; end
                end
                M_ENTER: begin
                    if (clear) m_digits = {};
                    else if (submit && m_digits.size() == 4) m_phase = M_CHECK;
                    else if (digit_valid && m_digits.size() < 4) m_digits.push_back(digit_in);
                end
                M_CHECK: begin
                    m_correct = (entry_value() == m_target);
                    m_phase = M_RESULT; m_ticks = 0;
                end
                M_RESULT: if (tick) begin
                    m_ticks++;
                    if (m_ticks == RT) begin
                        m_ticks = 0; m_digits = {};
                        if (m_correct) begin
                            m_score = (m_score < 255) ? m_score + 1 : 255;
                            m_target = int'(randInt);
                            m_phase = M_SHOW;
                        end else begin
                            m_lives--;
                            m_phase = (m_lives == 0) ? M_OVER : M_SHOW;
                        end
                        m_correct = 1'b0;
                    end
                end
                M_OVER: if (start) m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_displayPhase", 32'(displayPhase), 32'(m_phase == M_SHOW));
            chk("m_target",       32'(target),       32'(m_target));
            chk("m_userInt",      32'(userInt),      32'(entry_value()));
            chk("m_digit_cnt",    32'(digit_cnt),    32'(m_digits.size()));
            chk("m_inputReady",   32'(inputReady),   32'(m_phase == M_ENTER && m_digits.size() == 4));
            chk("m_result_valid", 32'(result_valid), 32'(m_phase == M_RESULT));
            chk("m_correct",      32'(correct),      32'(m_correct));
            chk("m_score",        32'(score),        32'(m_score));
            chk("m_lives",        32'(lives),        32'(m_lives));
            chk("m_game_over",    32'(game_over),    32'(m_phase == M_OVER));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic quiet();
        tick = 1'b0; start = 1'b0; digit_valid = 1'b0; clear = 1'b0; submit = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    task automatic enter_word(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) begin
            digit_in = v[i*4 +: 4]; digit_valid = 1'b1; cyc();
        end
        digit_valid = 1'b0;
    endtask

    // SHOW -> enter v -> submit -> CHECK -> RESULT -> end of RESULT
    task automatic play_round(input logic [15:0] v);
        ticks(ST);
        enter_word(v);
        submit = 1'b1; cyc(); submit = 1'b0;
        cyc();
        ticks(RT);
    endtask

    initial begin
        quiet(); rst = 1'b1; randInt = 16'h0000; digit_in = 4'h0;
        cyc(); chk_en = 1'b1; cyc(); cyc();
        rst = 1'b0;
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_show",  32'(displayPhase), 32'd0);

        // start a game and run the display phase
        randInt = 16'hA5C3; start = 1'b1; cyc(); start = 1'b0;
        chk("start_show",   32'(displayPhase), 32'd1);
        chk("start_target", 32'(target), 32'hA5C3);
        randInt = 16'h0F0F;
        ticks(ST - 1);
        chk("show_hold", 32'(displayPhase), 32'd1);
        ticks(1);
        chk("show_end", 32'(displayPhase), 32'd0);

        // correct entry, 5th digit ignored
        enter_word(16'hA5C3);
        chk("entry_val",   32'(userInt), 32'hA5C3);
        chk("entry_ready", 32'(inputReady), 32'd1);
        digit_in = 4'h7; digit_valid = 1'b1; cyc(); digit_valid = 1'b0;
        chk("fifth_digit", 32'(userInt), 32'hA5C3);
        submit = 1'b1; cyc(); submit = 1'b0;
        chk("lat_1", 32'(result_valid), 32'd0);
        cyc();
        chk("lat_2",     32'(result_valid), 32'd1);
        chk("correct_1", 32'(correct), 32'd1);
        ticks(RT);
        chk("win_score",  32'(score), 32'd1);
        chk("win_target", 32'(target), 32'h0F0F);
        chk("win_show",   32'(displayPhase), 32'd1);

        // early submit ignored, clear beats digit, then a wrong entry
        ticks(ST);
        for (int i = 1; i <= 3; i++) begin
            digit_in = 4'(i); digit_valid = 1'b1; cyc();
        end
        digit_valid = 1'b0;
        submit = 1'b1; cyc(); submit = 1'b0;
        cyc();
        chk("early_submit", 32'(result_valid), 32'd0);
        chk("early_cnt",    32'(digit_cnt), 32'd3);
        clear = 1'b1; digit_valid = 1'b1; digit_in = 4'h9; cyc();
        clear = 1'b0; digit_valid = 1'b0;
        chk("clear_val", 32'(userInt), 32'd0);
        chk("clear_cnt", 32'(digit_cnt), 32'd0);
        enter_word(16'hFF12);
        submit = 1'b1; cyc(); submit = 1'b0; cyc();
        chk("wrong_correct", 32'(correct), 32'd0);
        ticks(RT);
        chk("wrong_lives",  32'(lives), 32'd2);
        chk("wrong_target", 32'(target), 32'h0F0F);
        chk("wrong_show",   32'(displayPhase), 32'd1);

        // reset in the middle of entry
        ticks(ST);
        enter_word(16'h0000);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mrst_user",  32'(userInt), 32'd0);
        chk("mrst_cnt",   32'(digit_cnt), 32'd0);
        chk("mrst_lives", 32'(lives), 32'd3);
        chk("mrst_score", 32'(score), 32'd0);

        // one win, then three losses to game over
        randInt = 16'h1111; start = 1'b1; cyc(); start = 1'b0;
        randInt = 16'h2222;
        play_round(16'h1111);
        repeat (3) play_round(16'h0000);
        chk("over_flag",  32'(game_over), 32'd1);
        chk("over_lives", 32'(lives), 32'd0);
        cyc();
        chk("over_score", 32'(score), 32'd1);
        start = 1'b1; cyc();
        chk("over_idle", 32'(game_over | displayPhase), 32'd0);
        cyc(); start = 1'b0;
        chk("restart_show",  32'(displayPhase), 32'd1);
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_score", 32'(score), 32'd0);

        // randomized play, digits often steered toward the target
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            start       = ($urandom_range(0, 7) == 0);
            tick        = ($urandom_range(0, 1) == 1);
            digit_valid = ($urandom_range(0, 2) == 0);
            clear       = ($urandom_range(0, 15) == 0);
            submit      = ($urandom_range(0, 3) == 0);
            randInt     = 16'($urandom());
            if (m_digits.size() < 4 && $urandom_range(0, 3) != 0)
                digit_in = 4'(m_target >> (12 - 4 * m_digits.size()));
            else
                digit_in = 4'($urandom_range(0, 15));
            cyc();
        end
        quiet(); rst = 1'b0;

        // score saturation
        rst = 1'b1; cyc(); rst = 1'b0;
        randInt = 16'h5A5A; start = 1'b1; cyc(); start = 1'b0;
        repeat (257) play_round(16'h5A5A);
        chk("score_sat", 32'(score), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
